collatz_sweep_ctrl: RTL

Sequencer that drives a single Collatz iteration engine across a host-supplied range of start values [lo, hi]. For each value it issues one engine job and waits for the engine's result. It tracks the maximum iteration count and the smallest n that produced it. It sits between the host-facing pins and the Collatz engine; the engine is external and connects through the eng_* ports.

---
 rtl/collatz_sweep_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/collatz_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// collatz_sweep_ctrl
//
// Sequencer that sweeps an external Collatz iteration engine over a host range
// [lo, hi]. It issues one job per start value, waits for the engine result (or
// abandons the job after TIMEOUT wait cycles), and tracks the largest iteration
// count together with the smallest n that produced it.
//
// Parameters
//   W        width of start values (lo, hi, cur_n, max_n, eng_n)
//   CW       width of engine iteration count and max_count
//   TIMEOUT  maximum WAIT cycles per job before it is abandoned (>= 2)
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   start, lo, hi         host sweep request; sampled only while idle
//   abort                 host cancel; effective in ISSUE, WAIT and NEXT
//   busy                  high in every state except IDLE
//   done                  one-cycle pulse while in FINISH
//   err                   last sweep had an empty range (effective lo > hi)
//   aborted               last sweep was cancelled
//   timeout_flag          some job of the last sweep was abandoned
//   max_count, max_n      best count seen this sweep and the smallest n for it
//   cur_n                 value currently issued or awaited
//   eng_start, eng_n      one-cycle job launch and its operand
//   eng_done, eng_count   engine result strobe and result
// -----------------------------------------------------------------------------
module collatz_sweep_ctrl #(
    parameter int W       = 8,
    parameter int CW      = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  lo,
    input  logic [W-1:0]  hi,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          aborted,
    output logic          timeout_flag,
    output logic [CW-1:0] max_count,
    output logic [W-1:0]  max_n,
    output logic [W-1:0]  cur_n,
    output logic          eng_start,
    output logic [W-1:0]  eng_n,
    input  logic          eng_done,
    input  logic [CW-1:0] eng_count
);

    // The wait timer only has to reach TIMEOUT-1.
    localparam int            TW       = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_FINISH
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_hi;
    logic [W-1:0]   r_cur_n;
    logic [TW-1:0]  r_timer;
    logic [CW-1:0]  r_max_count;
    logic [W-1:0]   r_max_n;
    logic           r_err;
    logic           r_aborted;
    logic           r_timeout_flag;
    logic           r_busy;
    logic           r_done;
    logic           r_eng_start;

    // The engine is undefined at 0, so a zero lower bound starts the sweep at 1.
    logic [W-1:0]   w_lo_eff;
    assign w_lo_eff = (lo == '0) ? W'(1) : lo;

    // busy, done and eng_start are registered alongside the state: each one is
    // set on the transition into the state where it must be visible.
    // NOTE: every register below is assigned with <= so all of them update
    // together from the values of the previous cycle; a blocking = here would
    // let later statements see half-updated state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_hi           <= '0;
            r_cur_n        <= '0;
            r_timer        <= '0;
            r_max_count    <= '0;
            r_max_n        <= '0;
            r_err          <= 1'b0;
            r_aborted      <= 1'b0;
            r_timeout_flag <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_eng_start    <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_eng_start <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_hi           <= hi;
                        r_max_count    <= '0;
                        r_max_n        <= '0;
                        r_err          <= 1'b0;
                        r_aborted      <= 1'b0;
                        r_timeout_flag <= 1'b0;
                        r_busy         <= 1'b1;
                        if (w_lo_eff > hi) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end else begin
                            r_cur_n     <= w_lo_eff;
                            r_eng_start <= 1'b1;
                            r_state     <= S_ISSUE;
                        end
                    end
                end

                S_ISSUE: begin
                    r_timer <= '0;
                    if (abort) begin
                        r_aborted <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= S_FINISH;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    // abort wins over a same-cycle result, which is dropped.
                    if (abort) begin
                        r_aborted <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= S_FINISH;
                    end else if (eng_done) begin
                        // Strict compare: a tie keeps the earlier, smaller n.
                        if (eng_count > r_max_count) begin
                            r_max_count <= eng_count;
                            r_max_n     <= r_cur_n;
                        end
                        r_state <= S_NEXT;
                    end else if (r_timer == TMO_LAST) begin
                        r_timeout_flag <= 1'b1;
                        r_state        <= S_NEXT;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end

                S_NEXT: begin
                    // Compare before incrementing so hi = 2^W-1 never wraps.
                    if (abort) begin
                        r_aborted <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= S_FINISH;
                    end else if (r_cur_n == r_hi) begin
                        r_done  <= 1'b1;
                        r_state <= S_FINISH;
                    end else begin
                        r_cur_n     <= r_cur_n + W'(1);
                        r_eng_start <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end

                S_FINISH: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;
    assign aborted      = r_aborted;
    assign timeout_flag = r_timeout_flag;
    assign max_count    = r_max_count;
    assign max_n        = r_max_n;
    assign cur_n        = r_cur_n;
    assign eng_start    = r_eng_start;
    assign eng_n        = r_cur_n;

endmodule
